weight_fetch_ctrl: RTL and testbench

Sequencer that drives a synchronous weight ROM (1-cycle read latency, `enable`/`addr`/`data_o` style) for one BNN conv block. It walks ROM addresses `0..DATA_DEPTH-1` once per pass for a runtime number of passes, and absorbs the ROM latency with a 2-entry output buffer. Weights stream to the PE array over a valid/ready handshake. It sits between the block-level layer controller, which pulses `start`, and the conv datapath, which consumes `w_data`.

---
 rtl/ecg_acc_pkg.sv | 16 +
 rtl/weight_fetch_ctrl_if.sv | 31 +++
 rtl/weight_fetch_fifo2.sv | 66 ++++++
 rtl/weight_fetch_ctrl.sv | 171 +++++++++++++++++
 tb/tb_weight_fetch_ctrl.sv | 301 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ecg_acc_pkg.sv
// ecg_acc_pkg
// Shared definitions for the ECG accelerator conv-block control logic.
//   wfc_state_t   : weight fetch controller FSM states
//   WFC_BUF_DEPTH : entries in the weight fetch output buffer
package ecg_acc_pkg;

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        DRAIN,
        DONE
    } wfc_state_t;

    localparam int WFC_BUF_DEPTH = 2;

endpackage

// File: rtl/weight_fetch_ctrl_if.sv
// weight_fetch_ctrl_if
// Bundles the weight ROM read port and the weight stream to the PE array.
//   rom_en / rom_addr : ROM read request (controller -> ROM)
//   rom_data          : ROM output word, valid the cycle after rom_en
//   w_data / w_last   : weight word and end-of-pass tag (controller -> datapath)
//   w_valid / w_ready : valid/ready handshake for the weight stream
// Modports: master = weight fetch controller, slave = ROM + datapath side.
interface weight_fetch_ctrl_if #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 32
);

    logic                  rom_en;
    logic [ADDR_WIDTH-1:0] rom_addr;
    logic [DATA_WIDTH-1:0] rom_data;
    logic [DATA_WIDTH-1:0] w_data;
    logic                  w_valid;
    logic                  w_ready;
    logic                  w_last;

    modport master (
        output rom_en, rom_addr, w_data, w_valid, w_last,
        input  rom_data, w_ready
    );

    modport slave (
        input  rom_en, rom_addr, w_data, w_valid, w_last,
        output rom_data, w_ready
    );

endinterface

// File: rtl/weight_fetch_fifo2.sv
// weight_fetch_fifo2
// Two-entry register FIFO used to absorb the ROM read latency.
//   clk, rst  : clock and synchronous active-high reset
//   push      : write push_data this cycle
//   push_data : entry to write (weight word plus last tag)
//   pop       : discard the head entry this cycle
//   head      : current head entry (registered storage)
//   full      : both entries occupied
//   empty     : no entries occupied
module weight_fetch_fifo2
    import ecg_acc_pkg::*;
#(
    parameter int WIDTH = 33
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty
);

    logic [WIDTH-1:0] mem [WFC_BUF_DEPTH];
    logic             wr_ptr;
    logic             rd_ptr;
    logic [1:0]       count;
    logic             do_push;
    logic             do_pop;

    assign full  = (count == 2'(WFC_BUF_DEPTH));
    assign empty = (count == 2'd0);
    assign head  = mem[rd_ptr];

    // A push into a full FIFO is only legal when the head leaves in the same
    // cycle. The controller's credit check never lets that case arise
    // otherwise, so a blocked push here would indicate a controller bug.
    assign do_push = push && (!full || pop);
    assign do_pop  = pop && !empty;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < WFC_BUF_DEPTH; i++) begin
                mem[i] <= '0;
            end
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= ~wr_ptr;
            end
            if (do_pop) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/weight_fetch_ctrl.sv
// weight_fetch_ctrl
// Walks weight ROM addresses 0..DATA_DEPTH-1 once per pass for num_pass
// passes and streams the words to the PE array over valid/ready. A two-entry
// buffer plus a one-read in-flight credit hides the ROM's 1-cycle latency.
//   clk, rst  : clock and synchronous active-high reset
//   start     : job request, accepted only while idle
//   num_pass  : number of passes, latched on an accepted start
//   busy      : controller is not idle
//   done      : one-cycle pulse at job end
//   stall_cnt : cycles with w_valid && !w_ready while busy (optional)
//   bus       : ROM read port and weight stream (master modport)
// Optional feature macro: WEIGHT_FETCH_STALL_CNT_EN adds stall_cnt.
module weight_fetch_ctrl
    import ecg_acc_pkg::*;
#(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 32,
    parameter int DATA_DEPTH = 2,
    parameter int PASS_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [PASS_WIDTH-1:0] num_pass,
    output logic                  busy,
    output logic                  done,
`ifdef WEIGHT_FETCH_STALL_CNT_EN
    output logic [31:0]           stall_cnt,
`endif
    weight_fetch_ctrl_if.master   bus
);

    wfc_state_t state;
    wfc_state_t state_next;

    logic [ADDR_WIDTH-1:0] addr_cnt;
    logic [ADDR_WIDTH-1:0] addr_hold;
    logic [PASS_WIDTH-1:0] pass_cnt;
    logic [PASS_WIDTH-1:0] num_pass_q;
    logic                  inflight;
    logic                  inflight_last;
    logic                  issue;
    logic                  xfer;
    logic                  last_addr;
    logic                  final_pass;
    logic [1:0]            occupancy;
    logic                  credit_ok;

    logic [DATA_WIDTH:0]   fifo_head;
    logic                  fifo_full;
    logic                  fifo_empty;

    assign xfer       = bus.w_valid && bus.w_ready;
    assign last_addr  = (addr_cnt == ADDR_WIDTH'(DATA_DEPTH - 1));
    assign final_pass = (pass_cnt == num_pass_q - PASS_WIDTH'(1));

    // Occupancy is rebuilt from full/empty because a two-entry FIFO has only
    // three possible fill levels. Pops in the current cycle are deliberately
    // not counted, so issue resumes one cycle after a credit is freed.
    assign occupancy = {fifo_full, !fifo_full && !fifo_empty};
    assign credit_ok = ({1'b0, occupancy} + {2'b00, inflight}) < 3'(WFC_BUF_DEPTH);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and issue decision. The job leaves FETCH in the same cycle
    // the final address is issued; DRAIN ends as the last buffered word
    // leaves so that done lands one cycle after the final transfer.
    always_comb begin
        state_next = state;
        issue      = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_next = (num_pass == '0) ? DONE : FETCH;
                end
            end
            FETCH: begin
                issue = credit_ok;
                if (credit_ok && last_addr && final_pass) begin
                    state_next = DRAIN;
                end
            end
            DRAIN: begin
                if (!inflight && (fifo_empty || (xfer && !fifo_full))) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Address/pass counters and the one-deep record of the read in flight.
    // addr_hold keeps the last issued address visible on rom_addr between
    // issues and is returned to zero as the job finishes.
    always_ff @(posedge clk) begin
        if (rst) begin
            addr_cnt      <= '0;
            addr_hold     <= '0;
            pass_cnt      <= '0;
            num_pass_q    <= '0;
            inflight      <= 1'b0;
            inflight_last <= 1'b0;
        end else begin
            inflight      <= issue;
            inflight_last <= issue && last_addr;
            if (state == IDLE && start) begin
                num_pass_q <= num_pass;
                addr_cnt   <= '0;
                pass_cnt   <= '0;
            end else if (issue) begin
                addr_hold <= addr_cnt;
                if (last_addr) begin
                    addr_cnt <= '0;
                    pass_cnt <= pass_cnt + PASS_WIDTH'(1);
                end else begin
                    addr_cnt <= addr_cnt + ADDR_WIDTH'(1);
                end
            end
            if (state == DONE) begin
                addr_hold <= '0;
            end
        end
    end

    weight_fetch_fifo2 #(
        .WIDTH(DATA_WIDTH + 1)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (inflight),
        .push_data ({inflight_last, bus.rom_data}),
        .pop       (xfer),
        .head      (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    assign bus.rom_en   = issue;
    assign bus.rom_addr = issue ? addr_cnt : addr_hold;
    assign bus.w_valid  = !fifo_empty;
    assign bus.w_data   = fifo_head[DATA_WIDTH-1:0];
    assign bus.w_last   = fifo_head[DATA_WIDTH];
    assign busy         = (state != IDLE);
    assign done         = (state == DONE);

`ifdef WEIGHT_FETCH_STALL_CNT_EN
    // Back-pressure counter: saturates instead of wrapping and keeps its
    // value after the job so the layer controller can read it later.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt <= '0;
        end else if (state == IDLE && start) begin
            stall_cnt <= '0;
        end else if (busy && bus.w_valid && !bus.w_ready && (stall_cnt != '1)) begin
            stall_cnt <= stall_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_weight_fetch_ctrl.sv
// tb_weight_fetch_ctrl
// Drives two controller instances (DATA_DEPTH 2 and 7) with identical start,
// num_pass, w_ready and reset stimulus. Each instance has its own ROM model
// and is checked against an arithmetic model of the job: the n-th transfer
// must carry ROM word n mod DATA_DEPTH, reads may never exceed two
// outstanding words, and done/busy follow the job boundaries.
// Optional feature macro: WEIGHT_FETCH_STALL_CNT_EN (stall_cnt checks).
module tb_weight_fetch_ctrl;

    localparam int AW  = 8;
    localparam int DW  = 32;
    localparam int PW  = 8;
    localparam int DD0 = 2;
    localparam int DD1 = 7;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [PW-1:0] num_pass;
    logic          w_ready;
    logic          busy0, done0, busy1, done1;
`ifdef WEIGHT_FETCH_STALL_CNT_EN
    logic [31:0]   stall0, stall1;
`endif

    weight_fetch_ctrl_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus0 ();
    weight_fetch_ctrl_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus1 ();

    assign bus0.w_ready = w_ready;
    assign bus1.w_ready = w_ready;

    weight_fetch_ctrl #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DATA_DEPTH(DD0), .PASS_WIDTH(PW)
    ) dut0 (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .num_pass  (num_pass),
        .busy      (busy0),
        .done      (done0),
`ifdef WEIGHT_FETCH_STALL_CNT_EN
        .stall_cnt (stall0),
`endif
        .bus       (bus0)
    );

    weight_fetch_ctrl #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DATA_DEPTH(DD1), .PASS_WIDTH(PW)
    ) dut1 (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .num_pass  (num_pass),
        .busy      (busy1),
        .done      (done1),
`ifdef WEIGHT_FETCH_STALL_CNT_EN
        .stall_cnt (stall1),
`endif
        .bus       (bus1)
    );

    always #5 clk = ~clk;

    // Synchronous ROMs with one cycle of read latency.
    logic [DW-1:0] rom_mem [2][7];

    always @(posedge clk) begin
        if (bus0.rom_en) begin
            bus0.rom_data <= (int'(bus0.rom_addr) < DD0) ? rom_mem[0][int'(bus0.rom_addr)] : 32'hBAD0BAD0;
        end
    end

    always @(posedge clk) begin
        if (bus1.rom_en) begin
            bus1.rom_data <= (int'(bus1.rom_addr) < DD1) ? rom_mem[1][int'(bus1.rom_addr)] : 32'hBAD1BAD1;
        end
    end

    int check_count = 0;
    int error_count = 0;
    int cyc = 0;

    // Job model per lane: counts of issued reads and transfers, the job size,
    // and the expected busy/done levels for the current cycle.
    int issued      [2];
    int xfers       [2];
    int total       [2];
    int start_cyc   [2];
    int first_valid [2];
    int done_seen   [2];
    bit m_busy      [2];
    bit m_done      [2];

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        check_count++;
        if (observed !== expected) begin
            error_count++;
            $display("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    function automatic string laneTag(input int d, input string name);
        return $sformatf("lane%0d_%s", d, name);
    endfunction

    function automatic logic readyFor(input int mode, input int k);
        case (mode)
            0:       return 1'b1;
            1:       return !(k >= 3 && k <= 10);
            default: return 1'($urandom_range(0, 1));
        endcase
    endfunction

    task automatic resetModel();
        for (int d = 0; d < 2; d++) begin
            m_busy[d]      = 1'b0;
            m_done[d]      = 1'b0;
            issued[d]      = 0;
            xfers[d]       = 0;
            total[d]       = 0;
            first_valid[d] = -1;
            done_seen[d]   = 0;
        end
    endtask

    // Checks one lane for the current cycle, then advances its model.
    task automatic evalLane(input int d, input logic rom_en, input logic [AW-1:0] addr,
                            input logic w_valid, input logic [DW-1:0] w_data,
                            input logic w_last, input logic busy_o, input logic done_o);
        int  dd;
        int  a;
        bit  nb;
        bit  nd;
        bit  moved;
        dd    = (d == 0) ? DD0 : DD1;
        moved = w_valid && w_ready;

        checkOutput(laneTag(d, "done"), done_o, m_done[d]);
        checkOutput(laneTag(d, "busy"), busy_o, m_busy[d]);

        if (rom_en) begin
            checkOutput(laneTag(d, "issue_allowed"), m_busy[d] && (issued[d] < total[d]), 1'b1);
            checkOutput(laneTag(d, "issue_addr"), addr, issued[d] % dd);
            checkOutput(laneTag(d, "credit"), (issued[d] - xfers[d]) < 2, 1'b1);
            issued[d]++;
        end

        if (moved) begin
            a = xfers[d] % dd;
            checkOutput(laneTag(d, "xfer_allowed"), xfers[d] < total[d], 1'b1);
            checkOutput(laneTag(d, "w_data"), w_data, rom_mem[d][a]);
            checkOutput(laneTag(d, "w_last"), w_last, a == dd - 1);
            xfers[d]++;
        end

        if (w_valid && m_busy[d] && first_valid[d] < 0) begin
            first_valid[d] = cyc - start_cyc[d];
        end
        if (done_o) begin
            done_seen[d]++;
        end

        nb = m_busy[d];
        nd = 1'b0;
        if (m_done[d]) begin
            nb = 1'b0;
        end
        if (moved && m_busy[d] && xfers[d] == total[d]) begin
            nd = 1'b1;
        end
        if (start && !m_busy[d]) begin
            total[d]       = dd * int'(num_pass);
            issued[d]      = 0;
            xfers[d]       = 0;
            start_cyc[d]   = cyc;
            first_valid[d] = -1;
            done_seen[d]   = 0;
            nb             = 1'b1;
            nd             = (num_pass == '0);
        end
        m_busy[d] = nb;
        m_done[d] = nd;
    endtask

    // One clock cycle: drive inputs at the falling edge, check, then step.
    task automatic applyStimulus(input logic s, input logic [PW-1:0] n, input logic r, input logic rs);
        @(negedge clk);
        start    = s;
        num_pass = n;
        w_ready  = r;
        rst      = rs;
        #1;
        if (rs) begin
            resetModel();
        end else begin
            evalLane(0, bus0.rom_en, bus0.rom_addr, bus0.w_valid, bus0.w_data, bus0.w_last, busy0, done0);
            evalLane(1, bus1.rom_en, bus1.rom_addr, bus1.w_valid, bus1.w_data, bus1.w_last, busy1, done1);
        end
        @(posedge clk);
        cyc++;
    endtask

    task automatic checkResetOutputs();
        checkOutput("rst_rom_en0",   bus0.rom_en,   1'b0);
        checkOutput("rst_rom_addr0", bus0.rom_addr, '0);
        checkOutput("rst_w_data0",   bus0.w_data,   '0);
        checkOutput("rst_w_valid0",  bus0.w_valid,  1'b0);
        checkOutput("rst_w_last0",   bus0.w_last,   1'b0);
        checkOutput("rst_busy0",     busy0,         1'b0);
        checkOutput("rst_done0",     done0,         1'b0);
        checkOutput("rst_rom_en1",   bus1.rom_en,   1'b0);
        checkOutput("rst_rom_addr1", bus1.rom_addr, '0);
        checkOutput("rst_w_data1",   bus1.w_data,   '0);
        checkOutput("rst_w_valid1",  bus1.w_valid,  1'b0);
        checkOutput("rst_w_last1",   bus1.w_last,   1'b0);
        checkOutput("rst_busy1",     busy1,         1'b0);
        checkOutput("rst_done1",     done1,         1'b0);
`ifdef WEIGHT_FETCH_STALL_CNT_EN
        checkOutput("rst_stall0", stall0, 32'd0);
        checkOutput("rst_stall1", stall1, 32'd0);
`endif
    endtask

    // Runs a full job. restart_at re-pulses start mid-job with a different
    // num_pass, which must be ignored; num_pass is randomised off the start.
    task automatic runJob(input logic [PW-1:0] n, input int mode, input int restart_at);
        int k;
        applyStimulus(1'b1, n, readyFor(mode, 0), 1'b0);
        k = 1;
        while ((m_busy[0] || m_busy[1]) && k < 3000) begin
            applyStimulus(k == restart_at, PW'($urandom_range(1, 255)), readyFor(mode, k), 1'b0);
            k++;
        end
        checkOutput("job_within_budget", k < 3000, 1'b1);
        applyStimulus(1'b0, '0, 1'b1, 1'b0);
        applyStimulus(1'b0, '0, 1'b1, 1'b0);
        checkOutput("lane0_done_once", done_seen[0], 1);
        checkOutput("lane1_done_once", done_seen[1], 1);
    endtask

    initial begin
        int k;
        for (int d = 0; d < 2; d++) begin
            for (int a = 0; a < 7; a++) begin
                rom_mem[d][a] = $urandom;
            end
        end
        start    = 1'b0;
        num_pass = '0;
        w_ready  = 1'b0;
        rst      = 1'b1;
        resetModel();

        $display("[TB] reset");
        applyStimulus(1'b0, '0, 1'b0, 1'b1);
        applyStimulus(1'b0, '0, 1'b0, 1'b1);
        #1;
        checkResetOutputs();

        $display("[TB] three passes, w_ready high");
        runJob(8'd3, 0, -1);
        checkOutput("lane0_first_valid", first_valid[0], 3);
        checkOutput("lane1_first_valid", first_valid[1], 3);

        $display("[TB] three passes, w_ready low cycles 3-10");
        runJob(8'd3, 1, -1);
`ifdef WEIGHT_FETCH_STALL_CNT_EN
        checkOutput("lane0_stall_cnt", stall0, 32'd8);
        checkOutput("lane1_stall_cnt", stall1, 32'd8);
`endif

        $display("[TB] zero passes");
        runJob(8'd0, 0, -1);
        checkOutput("lane0_no_valid", first_valid[0], -1);
        checkOutput("lane1_no_valid", first_valid[1], -1);

        $display("[TB] restart pulse mid-job, random w_ready");
        runJob(8'd4, 2, 6);

        $display("[TB] reset after third transfer");
        applyStimulus(1'b1, 8'd3, 1'b1, 1'b0);
        k = 1;
        while (xfers[0] < 3 && k < 200) begin
            applyStimulus(1'b0, PW'($urandom_range(1, 255)), 1'b1, 1'b0);
            k++;
        end
        checkOutput("lane0_xfers_before_rst", xfers[0], 3);
        applyStimulus(1'b0, '0, 1'b0, 1'b1);
        #1;
        checkResetOutputs();
        runJob(8'd1, 0, -1);

        $display("[TB] five passes, random w_ready");
        runJob(8'd5, 2, -1);
        checkOutput("lane1_total_xfers", xfers[1], 35);

        $display("CHECKS %0d ERRORS %0d", check_count, error_count);
        $finish;
    end

endmodule
